// File: rtl/rx_data_sampler_if.sv
// Signal bundle between the RX FSM/driver side (master) and the oversampling
// data sampler (slave).
interface rx_data_sampler_if #(
  parameter int PS_W = 6
);
  logic            rx_in;
  logic            smp_en;
  logic [PS_W-1:0] prescale;
  logic            sampled_bit;
  logic            smp_valid;
  logic [PS_W-1:0] edge_cnt;
  logic [3:0]      bit_cnt;
  logic            bit_done;

  modport master (
    output rx_in, smp_en, prescale,
    input  sampled_bit, smp_valid, edge_cnt, bit_cnt, bit_done
  );

  modport slave (
    input  rx_in, smp_en, prescale,
    output sampled_bit, smp_valid, edge_cnt, bit_cnt, bit_done
  );
endinterface

// File: rtl/rx_data_sampler.sv
// UART-style RX oversampler: three-point majority vote around mid-bit.
// Define RX_SAMPLER_SYNC_EN to put a two-flop synchronizer in front of rx_in.
module rx_data_sampler #(
  parameter int PS_W = 6
) (
  input logic              clk,
  input logic              rst,
  rx_data_sampler_if.slave bus
);

  logic [PS_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PS_W-1:0] p_q, p_d;
  logic [PS_W-1:0] p_new, p_cur, mid, last;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            en_q, en_d;
  logic            smp_valid_q, smp_valid_d;
  logic            sampled_bit_q, sampled_bit_d;
  logic            s0_q, s0_d;
  logic            s1_q, s1_d;
  logic            rise;
  logic            line;

`ifdef RX_SAMPLER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], bus.rx_in};
  assign line   = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end
`else
  assign line = bus.rx_in;
`endif

  // The ratio is captured on the rising cycle itself so the first bit already
  // uses the new value; later prescale changes are ignored until re-enable.
  always_comb begin
    p_new = bus.prescale & ~PS_W'(1);
    if (p_new < PS_W'(4)) p_new = PS_W'(4);
  end

  assign rise  = bus.smp_en && !en_q;
  assign p_cur = rise ? p_new : p_q;
  assign mid   = p_cur >> 1;
  assign last  = p_cur - PS_W'(1);

  always_comb begin
    edge_cnt_d    = edge_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    p_d           = p_q;
    en_d          = bus.smp_en;
    smp_valid_d   = 1'b0;
    sampled_bit_d = sampled_bit_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    if (bus.smp_en) begin
      if (rise) p_d = p_new;
      if (edge_cnt_q == mid - PS_W'(1)) s0_d = line;
      if (edge_cnt_q == mid)            s1_d = line;
      if (edge_cnt_q == mid + PS_W'(1)) begin
        sampled_bit_d = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
        smp_valid_d   = 1'b1;
      end
      if (edge_cnt_q == last) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + PS_W'(1);
      end
    end else begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      p_q           <= PS_W'(8);
      en_q          <= 1'b0;
      smp_valid_q   <= 1'b0;
      sampled_bit_q <= 1'b1;
      s0_q          <= 1'b1;
      s1_q          <= 1'b1;
    end else begin
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      p_q           <= p_d;
      en_q          <= en_d;
      smp_valid_q   <= smp_valid_d;
      sampled_bit_q <= sampled_bit_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
    end
  end

  assign bus.edge_cnt    = edge_cnt_q;
  assign bus.bit_cnt     = bit_cnt_q;
  assign bus.smp_valid   = smp_valid_q;
  assign bus.sampled_bit = sampled_bit_q;
  assign bus.bit_done    = bus.smp_en && (edge_cnt_q == last);

endmodule

// File: tb/tb_rx_data_sampler.sv
// Randomized and directed bench for rx_data_sampler against a per-bit history
// model; honours RX_SAMPLER_SYNC_EN for the line latency.
module tb_rx_data_sampler;
  localparam int PS_W = 6;
`ifdef RX_SAMPLER_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = 2;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_data_sampler_if #(.PS_W(PS_W)) bus ();
  rx_data_sampler #(.PS_W(PS_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // reference model: position in bit, bit index, latched ratio, line history per bit
  int m_pos, m_bits, m_p, m_sb, m_valid, m_prev_en;
  int hist [64];
  int sh0, sh1;

  // last observed DUT outputs
  int o_edge, o_bit, o_valid, o_sb, o_done;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input int ps, input bit rx);
    int line, pe, mid;
    if (r) begin
      m_pos = 0; m_bits = 0; m_valid = 0; m_sb = 1; m_p = 8; m_prev_en = 0;
      sh0 = 1; sh1 = 1;
      return;
    end
    line = SYNC ? sh1 : int'(rx);
    sh1 = sh0;
    sh0 = int'(rx);
    m_valid = 0;
    if (en) begin
      if (m_prev_en == 0) begin
        pe = ps & 'h3e;
        if (pe < 4) pe = 4;
        m_p = pe;
      end
      mid = m_p / 2;
      hist[m_pos] = line;
      if (m_pos == mid + 1) begin
        m_sb = ((hist[mid-1] + hist[mid] + hist[mid+1]) >= 2) ? 1 : 0;
        m_valid = 1;
      end
      if (m_pos == m_p - 1) begin
        m_pos = 0;
        m_bits = (m_bits + 1) % 16;
      end else begin
        m_pos++;
      end
    end else begin
      m_pos = 0;
      m_bits = 0;
    end
    m_prev_en = int'(en);
  endtask

  // one clock: drive inputs, compare all outputs with the model, advance the model
  task automatic cyc(input bit r, input bit en, input int ps, input bit rx);
    @(negedge clk);
    rst = r;
    bus.smp_en = en;
    bus.prescale = ps[PS_W-1:0];
    bus.rx_in = rx;
    #1;
    o_edge  = int'(bus.edge_cnt);
    o_bit   = int'(bus.bit_cnt);
    o_valid = int'(bus.smp_valid);
    o_sb    = int'(bus.sampled_bit);
    o_done  = int'(bus.bit_done);
    check_eq("edge_cnt", o_edge, m_pos);
    check_eq("bit_cnt", o_bit, m_bits);
    check_eq("smp_valid", o_valid, m_valid);
    check_eq("sampled_bit", o_sb, m_sb);
    check_eq("bit_done", o_done, (en && m_pos == m_p - 1) ? 1 : 0);
    @(posedge clk);
    model_step(r, en, ps, rx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8, 1'b1);
  endtask

  // bit period measured between the first two bit_done pulses
  task automatic measure_period(input int ps0, input int ps1, input int exp_p, input string tag);
    int first, second;
    first = -1;
    second = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b1, (i < 3) ? ps0 : ps1, 1'(($urandom % 2)));
      if (o_done == 1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check_eq(tag, second - first, exp_p);
    idle(2);
  endtask

  initial begin
    int cnt, at_edge, prev, sb_before, rv;
    bit en_r, r_r;
    int ps_r;
    rst = 1'b1;
    bus.smp_en = 1'b0;
    bus.prescale = PS_W'(8);
    bus.rx_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_step(1'b1, 1'b0, 8, 1'b1);

    cyc(1'b1, 1'b0, 8, 1'b1);
    check_eq("rst_sampled_bit", o_sb, 1);
    idle(4);

    // 8x, line low for a whole bit
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, 8, (i < 8) ? 1'b0 : 1'b1);
      if (i == 6) check_eq("b8_valid_at6", o_valid, 1);
      if (i == 7) check_eq("b8_done_at7", o_done, 1);
      if (i == 8) begin
        check_eq("b8_bit_cnt", o_bit, 1);
        check_eq("b8_sampled", o_sb, 0);
      end
    end
    idle(3);

    // 16x, single-cycle glitch on the middle sample is outvoted
    cnt = 0;
    at_edge = -1;
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b1, 16, (i == 8 - LAT) ? 1'b0 : 1'b1);
      if (o_valid == 1) begin
        cnt++;
        at_edge = o_edge;
      end
    end
    check_eq("glitch_pulses", cnt, 1);
    check_eq("glitch_valid_edge", at_edge, 10);
    check_eq("glitch_sampled", o_sb, 1);
    idle(3);

    // 11 bits back to back
    cnt = 0;
    prev = -1;
    for (int i = 0; i < 89; i++) begin
      cyc(1'b0, 1'b1, 8, 1'(($urandom % 2)));
      if (o_valid == 1) begin
        cnt++;
        if (prev >= 0) check_eq("frame_spacing", i - prev, 8);
        prev = i;
      end
      if (i == 88) check_eq("frame_bit_cnt", o_bit, 11);
    end
    check_eq("frame_pulses", cnt, 11);
    idle(3);

    // enable dropped mid-bit at edge_cnt 4
    sb_before = o_sb;
    rv = (sb_before == 1) ? 0 : 1;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, (i < 4), 8, 1'(rv));
      if (o_valid == 1) cnt++;
      if (i == 4) check_eq("drop_edge_at_drop", o_edge, 4);
      if (i == 5) begin
        check_eq("drop_edge_cleared", o_edge, 0);
        check_eq("drop_bit_cleared", o_bit, 0);
      end
    end
    check_eq("drop_no_valid", cnt, 0);
    check_eq("drop_sb_held", o_sb, sb_before);
    idle(2);

    measure_period(3, 3, 4, "period_ps3");
    measure_period(7, 7, 6, "period_ps7");
    measure_period(8, 32, 8, "period_ps_change");

    // reset mid-bit, then re-enable with a line edge that the sync delay shifts
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 8, 1'b1);
      if (o_valid == 1) cnt++;
    end
    cyc(1'b1, 1'b1, 8, 1'b1);
    check_eq("rst_mid_edge_before", o_edge, 6);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8, (i < 4) ? 1'b0 : 1'b1);
      if (i == 0) begin
        check_eq("rst_mid_edge", o_edge, 0);
        check_eq("rst_mid_valid", o_valid, 0);
        check_eq("rst_mid_sb", o_sb, 1);
      end
      if (o_valid == 1) begin
        cnt++;
        check_eq("rst_first_sample", o_sb, SYNC ? 0 : 1);
      end
    end
    check_eq("rst_pulse_count", cnt, 1);
    idle(3);

    // random traffic
    en_r = 1'b0;
    ps_r = 8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 40 == 0) en_r = ~en_r;
      if ($urandom % 25 == 0) ps_r = int'($urandom % 64);
      r_r = ($urandom % 300 == 0);
      cyc(r_r, en_r, ps_r, 1'(($urandom % 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
